mac_host_sequencer: RTL and testbench
=====================================

Name: mac_host_sequencer

Overview:
Byte-serial host front end that sits directly upstream of the MAC datapath inside the Tiny Tapeout top. It decodes strobed commands from the pin bus, loads operands A/B, and issues single-cycle fire and clear pulses to the MAC core. It also snapshots the MAC accumulator and returns it one byte per read strobe. The top wires pin_* ports to ui_in/uio_in/uo_out.

Parameters:
DATA_W, 8, operand width (A, B, din)
ACC_W, 24, accumulator width from the MAC core
MAC_LAT, 2, cycles from mac_valid high until mac_acc reflects the new product (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low = ignore strobes
pin_din  in  DATA_W  operand byte from the host
pin_cmd  in  2  command: 00 LOAD_A, 01 LOAD_B_FIRE, 10 CLEAR, 11 READ
pin_strobe  in  1  command strobe, asynchronous to clk
pin_dout  out  8  readout byte
busy  out  1  high while the FSM is not in IDLE
overrun  out  1  sticky: strobe dropped while busy
snap_valid  out  1  snapshot held and pin_dout meaningful
mac_a  out  DATA_W  operand A to the MAC
mac_b  out  DATA_W  operand B to the MAC
mac_valid  out  1  one-cycle fire pulse
mac_clear  out  1  one-cycle accumulator clear pulse
mac_acc  in  ACC_W  accumulator value from the MAC

Behaviour:
- Reset: all outputs and registers are 0; FSM = IDLE.
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Strobe handling: pin_strobe passes through a 2-flop synchronizer, and a third flop detects the rising edge. An edge pulse E appears 3 cycles after the pin rises. pin_din and pin_cmd are sampled in the E cycle. The host holds them stable from strobe rise until strobe fall.
- When ena=0, E is suppressed and the FSM returns to IDLE on the next clock. Registers hold.
- E while busy=1: the command is dropped and overrun is set to 1.
- NBYTES = ceil(ACC_W/8) = 3 at default.
- FSM states: IDLE, FIRE, WAIT, CLR.
  - IDLE + E + LOAD_A: a_reg <= din. Stay in IDLE.
  - IDLE + E + LOAD_B_FIRE: b_reg <= din; snap_valid <= 0; go to FIRE.
  - FIRE: mac_valid=1 for exactly this cycle, with mac_a=a_reg and mac_b=b_reg. Go to WAIT with cnt=MAC_LAT-1.
  - WAIT: decrement cnt. At 0, go to IDLE. busy spans 1+MAC_LAT cycles after E.
  - IDLE + E + CLEAR: go to CLR.
  - CLR: mac_clear=1 for one cycle; overrun <= 0; snap_valid <= 0; idx <= 0. Go to IDLE.
  - IDLE + E + READ with snap_valid=0: snap <= mac_acc; idx <= 0; snap_valid <= 1.
  - IDLE + E + READ with snap_valid=1: idx <= idx+1, wrapping NBYTES-1 -> 0.
  - READ executes in 1 cycle; busy is not asserted.
- pin_dout is registered and equals snap byte[idx], LSB byte first. It updates the cycle after E.
  - Bits above ACC_W in the last byte read as 0.
  - pin_dout is 0 whenever snap_valid=0.
- mac_a and mac_b are continuous views of a_reg and b_reg. Operands persist across fires and clears.
- Reset mid-WAIT: the FSM goes to IDLE and all pulses are deasserted immediately. The MAC core resets on the same rst_n.
- E and the ena falling edge in the same cycle: ena wins and the command is dropped; overrun is not set.

Decomposition:
- Shared package mac_pkg holds:
  - cmd_e enum: LOAD_A, LOAD_B_FIRE, CLEAR, READ
  - state_e enum
  - NBYTES constant function
- Sub-module: mac_strobe_sync, holding the 2-flop synchronizer and rising-edge detector. Ports: clk, rst_n, async_in, edge_out.
- The bench provides a behavioural MAC model: acc += a*b, MAC_LAT latency, clear to 0.

Test Plan:
1. Reset, then LOAD_A 3, LOAD_B_FIRE 5, then READ ×3 -> mac_valid pulses once with a=3, b=5; pin_dout sequence 0x0F, 0x00, 0x00; snap_valid=1.
2. Continue from test 1: LOAD_A 200, LOAD_B_FIRE 200, then READ ×4 -> acc 40015 = 0x009C4F; pin_dout 0x4F, 0x9C, 0x00, then 0x4F (wrap).
3. Strobe during a LOAD_B_FIRE busy window, with MAC_LAT=2 and busy=1 for 3 cycles -> command dropped, overrun=1, acc unchanged. A following CLEAR -> mac_clear single pulse, overrun=0, next READ returns 0x00.
4. Hold ena=0, then issue LOAD_A 9 and LOAD_B_FIRE 9 -> no mac_valid and no register change. Raise ena and issue READ -> bytes equal the previous accumulator.
5. Assert rst_n low during WAIT -> busy, mac_valid and mac_clear go to 0 asynchronously; all outputs 0; FSM = IDLE after release.
6. Hold pin_strobe high for 20 cycles -> exactly one E and one command executed; edge seen exactly 3 cycles after rise.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC host sequencer: command codes, FSM states,
// and the accumulator byte-count helper.
package mac_pkg;

    typedef enum logic [1:0] {
        LOAD_A      = 2'b00,
        LOAD_B_FIRE = 2'b01,
        CLEAR       = 2'b10,
        READ        = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIRE = 2'b01,
        WAIT = 2'b10,
        CLR  = 2'b11
    } state_e;

    function automatic int nbytes(input int acc_w);
        return (acc_w + 7) / 8;
    endfunction

endpackage

// File: rtl/mac_strobe_sync.sv
// Two-flop synchronizer for the host strobe plus a history flop for rising-edge detect.
module mac_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_out = s2 & ~s3;

endmodule

// File: rtl/mac_host_sequencer.sv
// Byte-serial host front end for the MAC core: decodes strobed commands, fires and clears
// the MAC, and returns a snapshot of the accumulator one byte per read.
module mac_host_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] pin_din,
    input  logic [1:0]        pin_cmd,
    input  logic              pin_strobe,
    output logic [7:0]        pin_dout,
    output logic              busy,
    output logic              overrun,
    output logic              snap_valid,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid,
    output logic              mac_clear,
    input  logic [ACC_W-1:0]  mac_acc
);

    localparam int NB     = nbytes(ACC_W);
    localparam int SNAP_W = NB * 8;
    localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W  = $clog2(MAC_LAT + 1);

    state_e              state, state_nxt;
    logic [DATA_W-1:0]   a_reg, a_nxt, b_reg, b_nxt;
    logic [SNAP_W-1:0]   snap, snap_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                sv_nxt, ovr_nxt;
    logic [7:0]          dout_nxt;
    logic                strobe_edge, go, idle;
    cmd_e                cmd;

    mac_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pin_strobe),
        .edge_out (strobe_edge)
    );

    // ena gates the edge in the same cycle, so a falling ena beats a coincident strobe
    assign go   = strobe_edge & ena;
    assign cmd  = cmd_e'(pin_cmd);
    assign idle = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (go) begin
                    if (cmd == LOAD_B_FIRE) state_nxt = FIRE;
                    else if (cmd == CLEAR)  state_nxt = CLR;
                end
                FIRE:    state_nxt = WAIT;
                WAIT:    if (cnt == '0) state_nxt = IDLE;
                CLR:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        mac_valid = (state == FIRE);
        mac_clear = (state == CLR);
    end

    always_comb begin
        a_nxt   = a_reg;
        b_nxt   = b_reg;
        snap_nxt = snap;
        idx_nxt = idx;
        sv_nxt  = snap_valid;
        ovr_nxt = overrun;
        cnt_nxt = cnt;
        if (state == FIRE)
            cnt_nxt = CNT_W'(MAC_LAT - 1);
        else if (state == WAIT && cnt != '0)
            cnt_nxt = cnt - CNT_W'(1);
        if (state == CLR) begin
            ovr_nxt = 1'b0;
            sv_nxt  = 1'b0;
            idx_nxt = '0;
        end
        if (go && !idle)
            ovr_nxt = 1'b1;
        if (go && idle) begin
            case (cmd)
                LOAD_A: a_nxt = pin_din;
                LOAD_B_FIRE: begin
                    b_nxt  = pin_din;
                    sv_nxt = 1'b0;
                end
                READ: begin
                    if (!snap_valid) begin
                        snap_nxt = SNAP_W'(mac_acc);
                        idx_nxt  = '0;
                        sv_nxt   = 1'b1;
                    end else if (idx == IDX_W'(NB - 1)) begin
                        idx_nxt = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
        // Readout is computed from next-state so it lands the cycle after the edge
        dout_nxt = sv_nxt ? 8'(snap_nxt >> {idx_nxt, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            snap       <= '0;
            idx        <= '0;
            cnt        <= '0;
            snap_valid <= 1'b0;
            overrun    <= 1'b0;
            pin_dout   <= 8'h00;
        end else begin
            a_reg      <= a_nxt;
            b_reg      <= b_nxt;
            snap       <= snap_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            snap_valid <= sv_nxt;
            overrun    <= ovr_nxt;
            pin_dout   <= dout_nxt;
        end
    end

    assign mac_a = a_reg;
    assign mac_b = b_reg;

endmodule

// File: tb/tb_mac_host_sequencer.sv
// Directed bench for mac_host_sequencer with a behavioural two-cycle-latency MAC model.
module tb_mac_host_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  pin_din = '0;
    logic [1:0]  pin_cmd = '0;
    logic        pin_strobe = 1'b0;
    logic [7:0]  pin_dout;
    logic        busy, overrun, snap_valid, mac_valid, mac_clear;
    logic [7:0]  mac_a, mac_b;
    logic [23:0] mac_acc;

    int nchk = 0;
    int nerr = 0;

    mac_host_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pin_din    (pin_din),
        .pin_cmd    (pin_cmd),
        .pin_strobe (pin_strobe),
        .pin_dout   (pin_dout),
        .busy       (busy),
        .overrun    (overrun),
        .snap_valid (snap_valid),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_valid  (mac_valid),
        .mac_clear  (mac_clear),
        .mac_acc    (mac_acc)
    );

    always #5 clk = ~clk;

    // MAC model: product registered once, accumulated on the next edge -> visible 2 cycles after fire
    logic        pv;
    logic [15:0] pp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= 1'b0; pp <= '0; mac_acc <= '0;
        end else begin
            pv <= mac_valid;
            pp <= mac_a * mac_b;
            if (mac_clear)  mac_acc <= '0;
            else if (pv)    mac_acc <= mac_acc + 24'(pp);
        end
    end

    int vcnt = 0, ccnt = 0, bcnt = 0;
    logic [7:0] last_a = '0, last_b = '0;
    always @(posedge clk) begin
        if (rst_n && mac_valid) begin vcnt++; last_a = mac_a; last_b = mac_b; end
        if (rst_n && mac_clear) ccnt++;
        if (rst_n && busy) bcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        pin_cmd = c; pin_din = d; pin_strobe = 1'b1;
        repeat (5) @(negedge clk);
        pin_strobe = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    int v0, c0, b0, first;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", pin_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_sv", snap_valid, 0);
        chk("rst_ab", {mac_a, mac_b}, 0);
        chk("rst_pulses", {mac_valid, mac_clear}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 3*5 = 15
        send(2'b00, 8'd3);
        send(2'b01, 8'd5);
        chk("t1_vcnt", vcnt, 1);
        chk("t1_ab", {last_a, last_b}, {8'd3, 8'd5});
        send(2'b11, 8'd0); chk("t1_rd0", pin_dout, 8'h0F); chk("t1_sv", snap_valid, 1);
        send(2'b11, 8'd0); chk("t1_rd1", pin_dout, 8'h00);
        send(2'b11, 8'd0); chk("t1_rd2", pin_dout, 8'h00);

        // 2: 15 + 40000 = 0x009C4F, with wrap
        send(2'b00, 8'd200);
        send(2'b01, 8'd200);
        chk("t2_sv_cleared", {snap_valid, pin_dout}, 0);
        send(2'b11, 8'd0); chk("t2_rd0", pin_dout, 8'h4F);
        send(2'b11, 8'd0); chk("t2_rd1", pin_dout, 8'h9C);
        send(2'b11, 8'd0); chk("t2_rd2", pin_dout, 8'h00);
        send(2'b11, 8'd0); chk("t2_wrap", pin_dout, 8'h4F);

        // 3: second strobe lands in the busy window of a fire (a=200,b=1 -> acc 40215 = 0x9D17)
        v0 = vcnt; b0 = bcnt;
        @(negedge clk); pin_cmd = 2'b01; pin_din = 8'd1; pin_strobe = 1'b1;
        @(negedge clk); pin_strobe = 1'b0;
        @(negedge clk); pin_strobe = 1'b1;
        repeat (8) @(negedge clk); pin_strobe = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_vcnt", vcnt - v0, 1);
        chk("t3_busy_len", bcnt - b0, 3);
        chk("t3_ovr", overrun, 1);
        send(2'b11, 8'd0); chk("t3_rd", pin_dout, 8'h17);
        c0 = ccnt;
        send(2'b10, 8'd0);
        chk("t3_clr_pulse", ccnt - c0, 1);
        chk("t3_ovr_clr", {overrun, snap_valid}, 0);
        send(2'b11, 8'd0); chk("t3_rd_zero", {snap_valid, pin_dout}, {1'b1, 8'h00});

        // 4: ena low ignores strobes; acc = 2*3 = 6
        send(2'b00, 8'd2);
        send(2'b01, 8'd3);
        v0 = vcnt;
        @(negedge clk); ena = 1'b0;
        send(2'b00, 8'd9);
        send(2'b01, 8'd9);
        chk("t4_vcnt", vcnt - v0, 0);
        chk("t4_ab", {mac_a, mac_b}, {8'd2, 8'd3});
        chk("t4_busy", busy, 0);
        @(negedge clk); ena = 1'b1;
        send(2'b11, 8'd0); chk("t4_rd0", pin_dout, 8'h06);
        send(2'b11, 8'd0); chk("t4_rd1", pin_dout, 8'h00);

        // 5: async reset during WAIT
        @(negedge clk); pin_cmd = 2'b01; pin_din = 8'd4; pin_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async", {busy, mac_valid, mac_clear}, 0);
        chk("t5_outs", {pin_dout, overrun, snap_valid, mac_a, mac_b}, 0);
        pin_strobe = 1'b0;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_idle", {busy, mac_valid, mac_clear}, 0);

        // 6: long strobe -> one edge, visible 3 edges after rise
        first = 0;
        @(negedge clk); pin_cmd = 2'b00; pin_din = 8'h55; pin_strobe = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (first == 0 && mac_a == 8'h55) first = k;
        end
        @(negedge clk); pin_strobe = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_edge_lat", first, 3);
        v0 = vcnt;
        @(negedge clk); pin_cmd = 2'b01; pin_din = 8'd6; pin_strobe = 1'b1;
        repeat (20) @(negedge clk); pin_strobe = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_one_fire", vcnt - v0, 1);
        chk("t6_ovr", overrun, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
